router_port_scheduler: RTL and testbench



---
 rtl/router_sched_pkg.sv | 27 ++
 rtl/router_port_scheduler_rr_arbiter.sv | 36 +++
 rtl/router_port_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_router_port_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_sched_pkg.sv
// router_sched_pkg: shared types and constants
// for the router port scheduler.
package router_sched_pkg;

    localparam int NUM_OUT = 3;
    localparam int SRC_W   = 3;

    typedef logic [SRC_W-1:0] src_t;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_1   = 2'd1,
        DIR_2   = 2'd2,
        DIR_INV = 2'd3
    } dir_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic src_t wrap_inc(input src_t v, input int n);
        if (int'(v) >= n - 1) return '0;
        return v + src_t'(1);
    endfunction

endpackage

// File: rtl/router_port_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// searching upward from ptr with wrap-around.
module rr_arbiter
    import router_sched_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] req,
    input  src_t              ptr,
    output logic [NUM_IN-1:0] gnt,
    output src_t              idx,
    output logic              any_gnt
);

    // First pass covers ptr..top, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!any_gnt && req[i] && src_t'(i) >= ptr) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                idx     = src_t'(i);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!any_gnt && req[i] && src_t'(i) < ptr) begin
                any_gnt = 1'b1;
                gnt[i]  = 1'b1;
                idx     = src_t'(i);
            end
        end
    end

endmodule

// File: rtl/router_port_scheduler.sv
// router_port_scheduler: per-output packet-locked
// round-robin grant with credit flow control.
module router_port_scheduler
    import router_sched_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IN-1:0]    req_valid,
    input  logic [2*NUM_IN-1:0]  req_dir,
    input  logic [NUM_IN-1:0]    req_last,
    output logic [NUM_IN-1:0]    req_ready,
    input  logic [NUM_OUT-1:0]   credit_return,
    output logic [NUM_OUT-1:0]   out_valid,
    output logic [3*NUM_OUT-1:0] out_src,
    output logic [NUM_OUT-1:0]   out_last,
    output logic                 drop_pulse,
    output logic                 credit_err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_e              state_q  [NUM_OUT];
    state_e              state_d  [NUM_OUT];
    src_t                owner_q  [NUM_OUT];
    src_t                owner_d  [NUM_OUT];
    logic [NUM_IN-1:0]   mask_q   [NUM_OUT];
    logic [NUM_IN-1:0]   mask_d   [NUM_OUT];
    src_t                rr_q     [NUM_OUT];
    src_t                rr_d     [NUM_OUT];
    logic [CW-1:0]       credit_q [NUM_OUT];
    logic [CW-1:0]       credit_d [NUM_OUT];
    src_t                out_src_q [NUM_OUT];
    src_t                out_src_d [NUM_OUT];
    logic [NUM_OUT-1:0]  out_valid_q;
    logic [NUM_OUT-1:0]  out_valid_d;
    logic [NUM_OUT-1:0]  out_last_q;
    logic [NUM_OUT-1:0]  out_last_d;
    logic                drop_q;
    logic                drop_d;
    logic                credit_err_q;
    logic                credit_err_d;

    logic [NUM_IN-1:0]   owned;
    logic [NUM_IN-1:0]   cand    [NUM_OUT];
    logic [NUM_IN-1:0]   arb_gnt [NUM_OUT];
    src_t                arb_idx [NUM_OUT];
    logic [NUM_OUT-1:0]  arb_any;
    logic [NUM_OUT-1:0]  sel_valid;
    logic [NUM_OUT-1:0]  sel_last;
    logic [NUM_OUT-1:0]  xfer;
    logic [NUM_IN-1:0]   drop_vec;
    logic [NUM_IN-1:0]   rdy;

    // Ownership and per-output arbitration candidates.
    always_comb begin
        owned = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            owned = owned | mask_q[o];
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cand[o][i] = req_valid[i] && !owned[i]
                          && req_dir[2*i +: 2] == 2'(o);
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_arb
        rr_arbiter #(
            .NUM_IN (NUM_IN)
        ) u_arb (
            .req     (cand[g]),
            .ptr     (rr_q[g]),
            .gnt     (arb_gnt[g]),
            .idx     (arb_idx[g]),
            .any_gnt (arb_any[g])
        );
    end

    // Owner's flit view and credit-gated transfer per output.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            sel_valid[o] = |(mask_q[o] & req_valid);
            sel_last[o]  = |(mask_q[o] & req_last);
            xfer[o]      = state_q[o] == LOCKED && sel_valid[o]
                        && credit_q[o] != '0;
        end
    end

    // Ready: owners when credited, unowned dir=3 flits always.
    always_comb begin
        rdy      = '0;
        drop_vec = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!owned[i] && req_valid[i]
                && req_dir[2*i +: 2] == DIR_INV) begin
                rdy[i]      = 1'b1;
                drop_vec[i] = 1'b1;
            end
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            if (state_q[o] == LOCKED && credit_q[o] != '0) begin
                rdy = rdy | (mask_q[o] & req_valid);
            end
        end
    end

    assign req_ready = rdy;

    // Next-state: grant from IDLE, release on last transfer.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            mask_d[o]  = mask_q[o];
            rr_d[o]    = rr_q[o];
            unique case (state_q[o])
                IDLE: begin
                    if (arb_any[o]) begin
                        state_d[o] = LOCKED;
                        owner_d[o] = arb_idx[o];
                        mask_d[o]  = arb_gnt[o];
                    end
                end
                LOCKED: begin
                    if (xfer[o] && sel_last[o]) begin
                        state_d[o] = IDLE;
                        mask_d[o]  = '0;
                        rr_d[o]    = wrap_inc(owner_q[o], NUM_IN);
                    end
                end
                default: begin
                    state_d[o] = IDLE;
                    mask_d[o]  = '0;
                end
            endcase
        end
    end

    // FSM, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                mask_q[o]  <= '0;
                rr_q[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                mask_q[o]  <= mask_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

    // Credit update; a return at full saturates and flags.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            credit_d[o] = credit_q[o];
            unique case ({credit_return[o], xfer[o]})
                2'b10: begin
                    if (credit_q[o] == CRED_MAX) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_d[o] = credit_q[o] + CW'(1);
                    end
                end
                2'b01:   credit_d[o] = credit_q[o] - CW'(1);
                default: credit_d[o] = credit_q[o];
            endcase
        end
    end

    // Credit counters and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                credit_q[o] <= CRED_MAX;
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                credit_q[o] <= credit_d[o];
            end
            credit_err_q <= credit_err_d;
        end
    end

    // Forwarded-flit sideband for the next cycle.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            out_valid_d[o] = xfer[o];
            out_last_d[o]  = xfer[o] & sel_last[o];
            out_src_d[o]   = xfer[o] ? owner_q[o] : '0;
        end
        drop_d = |drop_vec;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            drop_q      <= 1'b0;
            for (int o = 0; o < NUM_OUT; o++) begin
                out_src_q[o] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
            for (int o = 0; o < NUM_OUT; o++) begin
                out_src_q[o] <= out_src_d[o];
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_src
        assign out_src[3*g +: 3] = out_src_q[g];
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign drop_pulse = drop_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_router_port_scheduler.sv
// tb_router_port_scheduler: directed packet scenarios
// plus random traffic against a cycle-level reference model.
module tb_router_port_scheduler;

    localparam int NI   = 4;
    localparam int NO   = 3;
    localparam int CRED = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   req_valid;
    logic [2*NI-1:0] req_dir;
    logic [NI-1:0]   req_last;
    logic [NI-1:0]   req_ready;
    logic [NO-1:0]   credit_return;
    logic [NO-1:0]   out_valid;
    logic [3*NO-1:0] out_src;
    logic [NO-1:0]   out_last;
    logic            drop_pulse;
    logic            credit_err;

    always #5 clk = ~clk;

    router_port_scheduler #(
        .NUM_IN  (NI),
        .CREDITS (CRED),
        .CW      (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dir       (req_dir),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_src       (out_src),
        .out_last      (out_last),
        .drop_pulse    (drop_pulse),
        .credit_err    (credit_err)
    );

    int errors = 0;
    int checks = 0;

    // stimulus state: flits left, packet length, direction, idle gap
    int          rem  [NI];
    int          plen [NI];
    int          pdir [NI];
    bit          gap  [NI];
    logic [NO-1:0] cret;

    // reference model state
    bit          m_locked [NO];
    int          m_owner  [NO];
    int          m_rr     [NO];
    int          m_credit [NO];
    bit          m_err;
    bit          m_drop;
    logic [NO-1:0] m_ov;
    logic [NO-1:0] m_ol;
    int          m_os [NO];

    // observations
    logic [NI-1:0] obs_rdy;
    logic          obs_drop;
    logic [NO-1:0] obs_ov;
    int            xfer_cnt [NO];
    int            q0 [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dir_of(input int i);
        return int'(req_dir[2*i +: 2]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_locked[o] = 0;
            m_owner[o]  = 0;
            m_rr[o]     = 0;
            m_credit[o] = CRED;
            m_os[o]     = 0;
            xfer_cnt[o] = 0;
        end
        m_ov   = '0;
        m_ol   = '0;
        m_err  = 0;
        m_drop = 0;
        q0.delete();
    endtask

    task automatic model_comb(output logic [NI-1:0] r);
        int own;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            own = -1;
            for (int o = 0; o < NO; o++)
                if (m_locked[o] && m_owner[o] == i) own = o;
            if (own >= 0)
                r[i] = req_valid[i] && m_credit[own] > 0;
            else
                r[i] = req_valid[i] && dir_of(i) == 3;
        end
    endtask

    task automatic model_step();
        int  own_of [NI];
        bit  x;
        int  w;
        int  c;
        bit  nd;
        for (int i = 0; i < NI; i++) own_of[i] = -1;
        for (int o = 0; o < NO; o++)
            if (m_locked[o]) own_of[m_owner[o]] = o;
        nd = 0;
        for (int i = 0; i < NI; i++)
            if (own_of[i] < 0 && req_valid[i] && dir_of(i) == 3) nd = 1;
        for (int o = 0; o < NO; o++) begin
            x = 0;
            m_ov[o] = 0;
            m_ol[o] = 0;
            m_os[o] = 0;
            if (m_locked[o]) begin
                w = m_owner[o];
                x = req_valid[w] && m_credit[o] > 0;
                if (x) begin
                    m_ov[o] = 1;
                    m_os[o] = w;
                    m_ol[o] = req_last[w];
                    if (req_last[w]) begin
                        m_locked[o] = 0;
                        m_rr[o] = (w + 1) % NI;
                    end
                end
            end else begin
                for (int k = 0; k < NI; k++) begin
                    c = (m_rr[o] + k) % NI;
                    if (!m_locked[o] && req_valid[c] && dir_of(c) == o
                        && own_of[c] < 0) begin
                        m_locked[o] = 1;
                        m_owner[o]  = c;
                    end
                end
            end
            if (credit_return[o] && !x && m_credit[o] == CRED)
                m_err = 1;
            else
                m_credit[o] = m_credit[o] + int'(credit_return[o]) - int'(x);
        end
        m_drop = nd;
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_drop", 32'(drop_pulse), 0);
        chk("rst_credit_err", 32'(credit_err), 0);
    endtask

    // one clock: drive, compare at negedge, advance model at posedge
    task automatic cycle();
        logic [NI-1:0]   er;
        logic [3*NO-1:0] esrc;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = rem[i] > 0 && !gap[i];
            req_last[i]  = rem[i] > 0 && ((rem[i] - 1) % plen[i] == 0);
            req_dir[2*i +: 2] = 2'(pdir[i]);
        end
        credit_return = cret;
        @(negedge clk);
        model_comb(er);
        for (int o = 0; o < NO; o++) esrc[3*o +: 3] = 3'(m_os[o]);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_src", 32'(out_src), 32'(esrc));
        chk("out_last", 32'(out_last), 32'(m_ol));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        obs_rdy  = req_ready;
        obs_drop = drop_pulse;
        obs_ov   = out_valid;
        for (int o = 0; o < NO; o++)
            if (out_valid[o]) xfer_cnt[o]++;
        if (out_valid[0]) q0.push_back(int'(out_src[2:0]));
        for (int i = 0; i < NI; i++)
            if (er[i]) rem[i]--;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until_done(input int bound);
        int n;
        bit busy;
        n = 0;
        busy = 1;
        while (busy && n < bound) begin
            cycle();
            n++;
            busy = 0;
            for (int i = 0; i < NI; i++) if (rem[i] > 0) busy = 1;
        end
        chk("drain_in_bound", 32'(busy), 0);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NI; i++) begin
            rem[i]  = 0;
            plen[i] = 1;
            pdir[i] = 0;
            gap[i]  = 0;
        end
        cret          = '0;
        req_valid     = '0;
        req_last      = '0;
        req_dir       = '0;
        credit_return = '0;
    endtask

    task automatic do_reset();
        clear_stim();
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // single 3-flit packet from in0 to output 1
        do_reset();
        rem[0] = 3; plen[0] = 3; pdir[0] = 1;
        run_cycles(1);
        chk("sp_grant_no_ready", 32'(obs_rdy[0]), 0);
        run_cycles(1);
        chk("sp_first_xfer", 32'(obs_rdy[0]), 1);
        run_cycles(4);
        chk("sp_flits_out", xfer_cnt[1], 3);
        chk("sp_flits_left", rem[0], 0);

        // round robin on output 0 with 1-flit packets
        do_reset();
        rem[0] = 2; rem[1] = 1; rem[2] = 1;
        run_until_done(20);
        run_cycles(2);
        chk("rr_count", q0.size(), 4);
        if (q0.size() == 4) begin
            chk("rr_0", q0[0], 0);
            chk("rr_1", q0[1], 1);
            chk("rr_2", q0[2], 2);
            chk("rr_3", q0[3], 0);
        end

        // credit stall on output 2
        do_reset();
        rem[3] = 6; plen[3] = 6; pdir[3] = 2;
        run_cycles(10);
        chk("cs_stalled_left", rem[3], 2);
        chk("cs_passed", xfer_cnt[2], 4);
        chk("cs_ready_low", 32'(obs_rdy[3]), 0);
        cret = 3'b100; run_cycles(1);
        cret = 3'b000; run_cycles(1);
        cret = 3'b100; run_cycles(1);
        cret = 3'b000;
        run_until_done(10);
        run_cycles(2);
        chk("cs_all_passed", xfer_cnt[2], 6);

        // transfer and return together, then overflow
        do_reset();
        rem[0] = 10; plen[0] = 10; pdir[0] = 0;
        run_cycles(3);
        cret = 3'b001; run_cycles(1);
        cret = 3'b000; run_cycles(6);
        chk("cr_flits_left", rem[0], 5);
        rem[0] = 0;
        for (int k = 0; k < 4; k++) begin
            cret = 3'b001; run_cycles(1);
            cret = 3'b000; run_cycles(1);
        end
        chk("cr_no_err_at_full", 32'(credit_err), 0);
        cret = 3'b001; run_cycles(1);
        cret = 3'b000; run_cycles(1);
        chk("cr_err_set", 32'(credit_err), 1);
        run_cycles(3);
        chk("cr_err_sticky", 32'(credit_err), 1);

        // invalid direction is dropped
        do_reset();
        rem[1] = 1; plen[1] = 1; pdir[1] = 3;
        run_cycles(1);
        chk("inv_ready", 32'(obs_rdy[1]), 1);
        run_cycles(1);
        chk("inv_drop", 32'(obs_drop), 1);
        chk("inv_no_out", 32'(obs_ov), 0);
        run_cycles(1);
        chk("inv_drop_once", 32'(obs_drop), 0);

        // asynchronous reset mid-packet
        do_reset();
        rem[0] = 4; plen[0] = 4; pdir[0] = 0;
        run_cycles(3);
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rem[0] = 4; plen[0] = 4;
        run_cycles(1);
        chk("mr_rearbitrate", 32'(obs_rdy[0]), 0);
        run_until_done(12);
        run_cycles(2);
        chk("mr_full_credits", xfer_cnt[0], 4);

        // random traffic
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NI; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    plen[i] = int'($urandom_range(1, 4));
                    rem[i]  = plen[i];
                    pdir[i] = int'($urandom_range(0, 3));
                end else if (rem[i] > 0 && $urandom_range(0, 9) == 0) begin
                    pdir[i] = int'($urandom_range(0, 3));
                end
                gap[i] = ($urandom_range(0, 3) == 0);
            end
            for (int o = 0; o < NO; o++)
                cret[o] = m_credit[o] < CRED && $urandom_range(0, 1) == 1;
            cycle();
        end
        clear_stim();
        run_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
